// File: rtl/pool_ctrl_if.sv
// Handshake bundle between the ReLU stage, the 2x2 max-pool datapath controls
// and the downstream window buffer. The controller uses the slave modport.
interface pool_ctrl_if;
  logic       relu_valid;
  logic       relu_ready;
  logic       pool_enable;
  logic [4:0] counter;
  logic       Sx;
  logic       Sy;
  logic       out_model;
  logic       pool_valid;
  logic       pool_ready;
  logic [3:0] pool_row;
  logic [3:0] pool_col;

  modport master (
    output relu_valid, pool_ready,
    input  relu_ready, pool_enable, counter, Sx, Sy, out_model,
           pool_valid, pool_row, pool_col
  );

  modport slave (
    input  relu_valid, pool_ready,
    output relu_ready, pool_enable, counter, Sx, Sy, out_model,
           pool_valid, pool_row, pool_col
  );
endinterface

// File: rtl/pool_ctrl.sv
// Sequencer for the 2x2 max-pooling unit: walks one raster feature map per start.
// Optional feature macro: POOL_CTRL_ABORT_EN adds an abort input.
//
// state | meaning
// IDLE  | waiting for start, config checked here
// RUN   | accepting pixels, advancing x/y
// DRAIN | all pixels taken, waiting for last window handshake
// DONE  | done pulse, back to IDLE next cycle
module pool_ctrl #(
  parameter int MAX_DIM  = 32,
  parameter int POOL_LAT = 1
) (
  input  logic       clk,
  input  logic       a_reset,
  input  logic       start,
  input  logic [5:0] cfg_width,
  input  logic [5:0] cfg_height,
  input  logic       cfg_out_model,
`ifdef POOL_CTRL_ABORT_EN
  input  logic       abort,
`endif
  pool_ctrl_if.slave pif,
  output logic       busy,
  output logic       done,
  output logic       cfg_err
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [5:0] MAX_W = 6'(MAX_DIM);

  state_t     state_q;
  logic [4:0] x_q, y_q, x_d, y_d;
  logic [5:0] width_q, height_q;
  logic       out_model_q, busy_q, done_q, cfg_err_q;

  logic       pv_q   [POOL_LAT];
  logic [3:0] prow_q [POOL_LAT];
  logic [3:0] pcol_q [POOL_LAT];
  logic       src_v  [POOL_LAT];
  logic [3:0] src_r  [POOL_LAT];
  logic [3:0] src_c  [POOL_LAT];

  logic abort_w, cfg_ok, out_valid, stall, relu_ready, accept;
  logic x_last, y_last, last_px, win_acc, pend, final_hs;

`ifdef POOL_CTRL_ABORT_EN
  assign abort_w = abort & (state_q != S_IDLE);
`else
  assign abort_w = 1'b0;
`endif

  assign cfg_ok = ~cfg_width[0] && ~cfg_height[0] &&
                  (cfg_width  >= 6'd2) && (cfg_width  <= MAX_W) &&
                  (cfg_height >= 6'd2) && (cfg_height <= MAX_W);

  assign out_valid  = pv_q[POOL_LAT-1];
  assign stall      = out_valid & ~pif.pool_ready;
  assign relu_ready = (state_q == S_RUN) & ~stall & ~abort_w;
  assign accept     = pif.relu_valid & relu_ready;

  assign x_last  = ({1'b0, x_q} == (width_q  - 6'd1));
  assign y_last  = ({1'b0, y_q} == (height_q - 6'd1));
  assign last_px = x_last & y_last;
  assign win_acc = accept & x_q[0] & y_q[0];

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (accept) begin
      if (x_last) begin
        x_d = 5'd0;
        y_d = y_last ? 5'd0 : y_q + 5'd1;
      end else begin
        x_d = x_q + 5'd1;
      end
    end
  end

  // Window latency pipeline; the last stage is the held pool_valid output.
  always_comb begin
    src_v[0] = win_acc;
    src_r[0] = y_q[4:1];
    src_c[0] = x_q[4:1];
    for (int i = 1; i < POOL_LAT; i++) begin
      src_v[i] = pv_q[i-1];
      src_r[i] = prow_q[i-1];
      src_c[i] = pcol_q[i-1];
    end
    pend = 1'b0;
    for (int i = 0; i < POOL_LAT - 1; i++) pend = pend | pv_q[i];
  end

  assign final_hs = (state_q == S_DRAIN) & out_valid & pif.pool_ready & ~pend;

  always_ff @(posedge clk or posedge a_reset) begin
    if (a_reset) begin
      state_q     <= S_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      width_q     <= '0;
      height_q    <= '0;
      out_model_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
      for (int i = 0; i < POOL_LAT; i++) begin
        pv_q[i]   <= 1'b0;
        prow_q[i] <= '0;
        pcol_q[i] <= '0;
      end
    end else begin
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      x_q       <= x_d;
      y_q       <= y_d;

      // No accepts happen while stalled, so freezing the whole pipeline loses nothing.
      if (!stall) begin
        for (int i = 0; i < POOL_LAT; i++) begin
          pv_q[i] <= src_v[i];
          if (src_v[i]) begin
            prow_q[i] <= src_r[i];
            pcol_q[i] <= src_c[i];
          end
        end
      end

      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              state_q     <= S_RUN;
              busy_q      <= 1'b1;
              width_q     <= cfg_width;
              height_q    <= cfg_height;
              out_model_q <= cfg_out_model;
              x_q         <= '0;
              y_q         <= '0;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (accept && last_px) state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          if (final_hs) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase

      if (abort_w) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
        done_q  <= 1'b0;
        x_q     <= '0;
        y_q     <= '0;
        for (int i = 0; i < POOL_LAT; i++) pv_q[i] <= 1'b0;
      end
    end
  end

  assign pif.relu_ready  = relu_ready;
  assign pif.pool_enable = accept;
  assign pif.counter     = x_q;
  assign pif.Sx          = x_q[0];
  assign pif.Sy          = y_q[0];
  assign pif.out_model   = out_model_q;
  assign pif.pool_valid  = out_valid;
  assign pif.pool_row    = prow_q[POOL_LAT-1];
  assign pif.pool_col    = pcol_q[POOL_LAT-1];
  assign busy            = busy_q;
  assign done            = done_q;
  assign cfg_err         = cfg_err_q;

endmodule

// File: tb/tb_pool_ctrl.sv
// Self-checking bench for pool_ctrl: table of map runs with a window scoreboard,
// plus hand sequences for config errors, mid-map reset and (if built) abort.
module tb_pool_ctrl;
  logic       clk = 1'b0;
  logic       a_reset;
  logic       start;
  logic [5:0] cfg_width, cfg_height;
  logic       cfg_out_model;
  logic       busy, done, cfg_err;
`ifdef POOL_CTRL_ABORT_EN
  logic       abort;
`endif

  pool_ctrl_if pif ();

  pool_ctrl dut (
    .clk          (clk),
    .a_reset      (a_reset),
    .start        (start),
    .cfg_width    (cfg_width),
    .cfg_height   (cfg_height),
    .cfg_out_model(cfg_out_model),
`ifdef POOL_CTRL_ABORT_EN
    .abort        (abort),
`endif
    .pif          (pif.slave),
    .busy         (busy),
    .done         (done),
    .cfg_err      (cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct { int w; int h; int om; int gap; int stall; } vec_t;
  typedef struct { int row; int col; } win_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  win_t sbq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag, input int exp_om);
    chk({tag, "/busy"},        busy, 0);
    chk({tag, "/done"},        done, 0);
    chk({tag, "/cfg_err"},     cfg_err, 0);
    chk({tag, "/relu_ready"},  pif.relu_ready, 0);
    chk({tag, "/pool_enable"}, pif.pool_enable, 0);
    chk({tag, "/pool_valid"},  pif.pool_valid, 0);
    chk({tag, "/counter"},     pif.counter, 0);
    chk({tag, "/Sx"},          pif.Sx, 0);
    chk({tag, "/Sy"},          pif.Sy, 0);
    chk({tag, "/pool_row"},    pif.pool_row, 0);
    chk({tag, "/pool_col"},    pif.pool_col, 0);
    chk({tag, "/out_model"},   pif.out_model, 32'(exp_om));
  endtask

  // Feed pixels until n are accepted; returns with the last accept clocked in.
  task automatic feed(input int n, input string tag);
    int acc = 0;
    int guard = 0;
    while (acc < n && guard < 200) begin
      pif.relu_valid = 1'b1;
      pif.pool_ready = 1'b1;
      #1;
      if (pif.pool_enable === 1'b1) acc++;
      tick();
      guard++;
    end
    chk({tag, "/feed_count"}, acc, n);
  endtask

  task automatic run_map(input vec_t v, input string tag);
    int mx = 0, my = 0, acc = 0, wins = 0, dones = 0, cyc = 0;
    int last_hs = -10;
    int stall_left = v.stall;
    bit prev_win = 0, fin = 0, exp_rdy;
    win_t e;
    sbq.delete();
    cfg_width = 6'(v.w); cfg_height = 6'(v.h); cfg_out_model = 1'(v.om);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "/busy_after_start"}, busy, 1);
    chk({tag, "/out_model"}, pif.out_model, 32'(v.om));
    while (!fin && cyc < 3000) begin
      start = 1'b0;
      if (cyc == 2) begin start = 1'b1; cfg_width = 6'd3; end
      if (done === 1'b1) begin start = 1'b1; cfg_width = 6'(v.w); end
      pif.relu_valid = (acc < v.w * v.h) && (cyc % v.gap == 0);
      pif.pool_ready = !(stall_left > 0 && pif.pool_valid === 1'b1);
      #1;
      if (cyc == 3) chk({tag, "/start_while_busy"}, cfg_err, 0);
      exp_rdy = (acc < v.w * v.h) && !(pif.pool_valid && !pif.pool_ready);
      chk({tag, "/relu_ready"}, pif.relu_ready, 32'(exp_rdy));
      chk({tag, "/pool_enable"}, pif.pool_enable, 32'(pif.relu_valid && exp_rdy));
      if (pif.pool_valid && !pif.pool_ready) stall_left--;
      if (acc < v.w * v.h) begin
        chk({tag, "/counter"}, pif.counter, 32'(mx));
        chk({tag, "/Sx"}, pif.Sx, 32'(mx % 2));
        chk({tag, "/Sy"}, pif.Sy, 32'(my % 2));
      end
      if (prev_win) chk({tag, "/pool_valid_rise"}, pif.pool_valid, 1);
      prev_win = 0;
      if (pif.pool_valid === 1'b1) begin
        chk({tag, "/window_expected"}, sbq.size() > 0, 1);
        if (sbq.size() > 0) begin
          chk({tag, "/pool_row"}, pif.pool_row, 32'(sbq[0].row));
          chk({tag, "/pool_col"}, pif.pool_col, 32'(sbq[0].col));
        end
      end
      if (pif.pool_enable === 1'b1) begin
        if (mx % 2 == 1 && my % 2 == 1) begin
          e.row = my / 2; e.col = mx / 2;
          sbq.push_back(e);
          prev_win = 1;
        end
        acc++;
        if (mx == v.w - 1) begin mx = 0; my++; end
        else mx++;
      end
      if (pif.pool_valid === 1'b1 && pif.pool_ready && sbq.size() > 0) begin
        void'(sbq.pop_front());
        wins++;
        last_hs = cyc;
      end
      if (done === 1'b1) begin
        dones++;
        chk({tag, "/done_timing"}, cyc, last_hs + 1);
        fin = 1;
      end
      cyc++;
      tick();
    end
    start = 1'b0;
    pif.relu_valid = 1'b0;
    chk({tag, "/finished_in_budget"}, fin, 1);
    chk({tag, "/accepts"}, acc, v.w * v.h);
    chk({tag, "/windows"}, wins, v.w * v.h / 4);
    chk({tag, "/done_count"}, dones, 1);
    chk({tag, "/scoreboard_empty"}, sbq.size(), 0);
    chk({tag, "/busy_after_done"}, busy, 0);
    chk({tag, "/done_pulse_width"}, done, 0);
  endtask

  vec_t vecs[7];
  int   errs[4][2];

  initial begin
    vecs[0] = '{w: 4,  h: 4,  om: 1, gap: 1, stall: 0};
    vecs[1] = '{w: 4,  h: 4,  om: 1, gap: 1, stall: 3};
    vecs[2] = '{w: 2,  h: 4,  om: 1, gap: 3, stall: 0};
    vecs[3] = '{w: 2,  h: 2,  om: 0, gap: 1, stall: 0};
    vecs[4] = '{w: 6,  h: 2,  om: 1, gap: 2, stall: 2};
    vecs[5] = '{w: 32, h: 2,  om: 0, gap: 1, stall: 1};
    vecs[6] = '{w: 2,  h: 32, om: 1, gap: 1, stall: 0};
    errs = '{'{3, 4}, '{4, 0}, '{34, 2}, '{4, 5}};

    a_reset = 1'b1; start = 1'b0; cfg_width = '0; cfg_height = '0; cfg_out_model = 1'b0;
    pif.relu_valid = 1'b0; pif.pool_ready = 1'b0;
`ifdef POOL_CTRL_ABORT_EN
    abort = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("reset", 1);
    a_reset = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) run_map(vecs[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 4; i++) begin
      cfg_width = 6'(errs[i][0]); cfg_height = 6'(errs[i][1]); cfg_out_model = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk($sformatf("cfgerr%0d/pulse", i), cfg_err, 1);
      chk($sformatf("cfgerr%0d/busy", i), busy, 0);
      tick();
      chk($sformatf("cfgerr%0d/pulse_end", i), cfg_err, 0);
      chk($sformatf("cfgerr%0d/still_idle", i), busy, 0);
    end
    run_map('{w: 2, h: 2, om: 0, gap: 1, stall: 0}, "after_cfgerr");

    // Mid-map reset on an 8x2 map after six pixels.
    cfg_width = 6'd8; cfg_height = 6'd2; cfg_out_model = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    feed(6, "midreset");
    chk("midreset/counter_before", pif.counter, 6);
    pif.relu_valid = 1'b1;
    a_reset = 1'b1;
    #1;
    chk_reset_vals("midreset", 1);
    tick();
    a_reset = 1'b0;
    pif.relu_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("midreset/no_done", done, 0);
      chk("midreset/no_window", pif.pool_valid, 0);
    end
    run_map('{w: 2, h: 2, om: 1, gap: 1, stall: 0}, "after_reset");

`ifdef POOL_CTRL_ABORT_EN
    cfg_width = 6'd4; cfg_height = 6'd4; cfg_out_model = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    feed(5, "abort");
    pif.relu_valid = 1'b1;
    abort = 1'b1;
    start = 1'b1;
    #1;
    chk("abort/relu_ready", pif.relu_ready, 0);
    chk("abort/pool_enable", pif.pool_enable, 0);
    tick();
    abort = 1'b0;
    start = 1'b0;
    pif.relu_valid = 1'b0;
    chk("abort/busy", busy, 0);
    chk("abort/pool_valid", pif.pool_valid, 0);
    chk("abort/counter", pif.counter, 0);
    chk("abort/Sy", pif.Sy, 0);
    chk("abort/out_model_kept", pif.out_model, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("abort/no_done", done, 0);
      chk("abort/stays_idle", busy, 0);
    end
    run_map('{w: 4, h: 4, om: 1, gap: 1, stall: 0}, "after_abort");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
